// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-host handshake bundle for uart_rx_fifo: the receiver write strobe, the host read port
// and the status/flow-control flags. The FIFO side uses the slave modport.
interface uart_rx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              rx_done;
  logic [7:0]        rx_data;
  logic              parity_error;
  logic              rd_en;
  logic [7:0]        rd_data;
  logic              rd_perr;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overrun;
  logic              clr_overrun;
  logic              rts_n_out;

  modport master (
    output rx_done, rx_data, parity_error, rd_en, clr_overrun,
    input  rd_data, rd_perr, rd_valid, empty, full, count, overrun, rts_n_out
  );

  modport slave (
    input  rx_done, rx_data, parity_error, rd_en, clr_overrun,
    output rd_data, rd_perr, rd_valid, empty, full, count, overrun, rts_n_out
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: captures characters on rx_done, serves a registered host read port, and drives RTS
// and a sticky overrun flag. Define UART_RX_FIFO_PERR_TAG_EN to store and return the parity-error tag.
module uart_rx_fifo #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_fifo_if.slave  bus
);

`ifdef UART_RX_FIFO_PERR_TAG_EN
  localparam int ENTRY_W = 9;
`else
  localparam int ENTRY_W = 8;
`endif

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   THRESH_C = (ADDR_W+1)'(AFULL_THRESH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W+1)'(0);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);

  logic [ENTRY_W-1:0] mem_r [DEPTH];

  logic               wr_pend_r;
  logic [ADDR_W-1:0]  wr_ptr_r;
  logic [ADDR_W-1:0]  rd_ptr_r;
  logic [ADDR_W:0]    count_r;
  logic               empty_r;
  logic               full_r;
  logic               overrun_r;
  logic               rts_r;
  logic [7:0]         rd_data_r;
  logic               rd_perr_r;
  logic               rd_valid_r;

  logic               rd_acc_s;
  logic               wr_acc_s;
  logic               drop_s;
  logic [ADDR_W:0]    count_next_s;
  logic               overrun_next_s;
  logic [ENTRY_W-1:0] wr_word_s;
  logic [ENTRY_W-1:0] rd_word_s;

`ifdef UART_RX_FIFO_PERR_TAG_EN
  assign wr_word_s = {bus.parity_error, bus.rx_data};
`else
  assign wr_word_s = bus.rx_data;
  logic unused_perr_s;
  assign unused_perr_s = bus.parity_error;
`endif

  assign rd_word_s = mem_r[rd_ptr_r];

  // Accept/drop decisions and next occupancy; a full FIFO still accepts a write paired with a read.
  always_comb begin
    rd_acc_s       = 1'b0;
    wr_acc_s       = 1'b0;
    drop_s         = 1'b0;
    count_next_s   = count_r;
    overrun_next_s = overrun_r;

    rd_acc_s = bus.rd_en && (count_r != CNT_ZERO);
    wr_acc_s = wr_pend_r && ((count_r != DEPTH_C) || rd_acc_s);
    drop_s   = wr_pend_r && (count_r == DEPTH_C) && !rd_acc_s;

    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase

    if (drop_s) begin
      overrun_next_s = 1'b1;
    end else if (bus.clr_overrun) begin
      overrun_next_s = 1'b0;
    end else begin
      overrun_next_s = overrun_r;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= wr_word_s;
    end
  end

  // Pointers, occupancy, status flags and the registered read port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_pend_r  <= 1'b0;
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      overrun_r  <= 1'b0;
      rts_r      <= 1'b0;
      rd_data_r  <= 8'h00;
      rd_perr_r  <= 1'b0;
      rd_valid_r <= 1'b0;
    end else begin
      wr_pend_r <= bus.rx_done;
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_acc_s) begin
        rd_ptr_r  <= rd_ptr_r + PTR_ONE;
        rd_data_r <= rd_word_s[7:0];
`ifdef UART_RX_FIFO_PERR_TAG_EN
        rd_perr_r <= rd_word_s[ENTRY_W-1];
`else
        rd_perr_r <= 1'b0;
`endif
      end
      rd_valid_r <= rd_acc_s;
      count_r    <= count_next_s;
      empty_r    <= (count_next_s == CNT_ZERO);
      full_r     <= (count_next_s == DEPTH_C);
      overrun_r  <= overrun_next_s;
      rts_r      <= (count_next_s >= THRESH_C);
    end
  end

  assign bus.rd_data   = rd_data_r;
  assign bus.rd_perr   = rd_perr_r;
  assign bus.rd_valid  = rd_valid_r;
  assign bus.empty     = empty_r;
  assign bus.full      = full_r;
  assign bus.count     = count_r;
  assign bus.overrun   = overrun_r;
  assign bus.rts_n_out = rts_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: table-driven write/read vectors with a read-data scoreboard,
// plus hand-written reset-mid-stream and back-to-back read sequences.
module tb_uart_rx_fifo;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int THRESH = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .AFULL_THRESH(THRESH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       perr;
    logic       rd;
    logic       clr;
    logic       keep;
    int         exp_count;
    logic       exp_ovr;
    logic       exp_rv;
  } vec_t;

  vec_t       vecs[$];
  logic [8:0] sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_perr(input logic p);
`ifdef UART_RX_FIFO_PERR_TAG_EN
    return p;
`else
    return 1'b0;
`endif
  endfunction

  task automatic add(input logic wr, input logic [7:0] d, input logic p, input logic rd, input logic clr,
                     input logic keep, input int cnt, input logic ovr, input logic rv);
    vec_t v;
    v.wr = wr; v.data = d; v.perr = p; v.rd = rd; v.clr = clr; v.keep = keep;
    v.exp_count = cnt; v.exp_ovr = ovr; v.exp_rv = rv;
    vecs.push_back(v);
  endtask

  task automatic check_flags(input string tag, input int cnt, input logic ovr);
    chk({tag, "_count"}, 32'(bus.count), 32'(cnt));
    chk({tag, "_empty"}, 32'(bus.empty), 32'(cnt == 0));
    chk({tag, "_full"},  32'(bus.full),  32'(cnt == DEPTH));
    chk({tag, "_rts"},   32'(bus.rts_n_out), 32'(cnt >= THRESH));
    chk({tag, "_ovr"},   32'(bus.overrun), 32'(ovr));
  endtask

  // Cycle A: rx_done pulse. Cycle B: character + rd_en/clr. Cycle C: results visible.
  task automatic apply(input vec_t v, input string tag);
    bus.rx_done = v.wr; bus.rd_en = 1'b0; bus.clr_overrun = 1'b0;
    tick();
    bus.rx_done = 1'b0; bus.rx_data = v.data; bus.parity_error = v.perr;
    bus.rd_en = v.rd; bus.clr_overrun = v.clr;
    if (v.keep) sb_q.push_back({exp_perr(v.perr), v.data});
    tick();
    bus.rd_en = 1'b0; bus.clr_overrun = 1'b0; bus.rx_data = 8'h00; bus.parity_error = 1'b0;
    check_flags(tag, v.exp_count, v.exp_ovr);
    chk({tag, "_rv"}, 32'(bus.rd_valid), 32'(v.exp_rv));
    tick();
  endtask

  // Scoreboard: every rd_valid pulse must match the oldest expected character.
  always @(negedge clk) begin
    if (rst_n && bus.rd_valid) begin
      if (sb_q.size() == 0) begin
        chk("rd_unexpected", 32'(bus.rd_data), 32'hFFFF_FFFF);
      end else begin
        logic [8:0] e;
        e = sb_q.pop_front();
        chk("rd_data", 32'(bus.rd_data), 32'(e[7:0]));
        chk("rd_perr", 32'(bus.rd_perr), 32'(e[8]));
      end
    end
  end

  initial begin
    bus.rx_done = 1'b0; bus.rx_data = 8'h00; bus.parity_error = 1'b0;
    bus.rd_en = 1'b0; bus.clr_overrun = 1'b0;

    add(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    add(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++)
      add(1'b1, 8'(i), i[0], 1'b0, 1'b0, 1'b1, i + 1, 1'b0, 1'b0);
    add(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 16, 1'b1, 1'b0);
    add(1'b1, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0, 16, 1'b1, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16, 1'b0, 1'b0);
    add(1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b1, 16, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++)
      add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 15 - i, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    add(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);

    tick();
    tick();
    check_flags("reset", 0, 1'b0);
    chk("reset_rd_data", 32'(bus.rd_data), 32'h0);
    chk("reset_rd_perr", 32'(bus.rd_perr), 32'h0);
    chk("reset_rv", 32'(bus.rd_valid), 32'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("v%0d", i));

    // Reset mid-stream: five entries stored, reset lands while a read is requested.
    for (int i = 0; i < 5; i++)
      apply('{1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0, 1'b1, i + 1, 1'b0, 1'b0}, "rs_fill");
    bus.rd_en = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.rd_en = 1'b0;
    sb_q.delete();
    check_flags("rs_after", 0, 1'b0);
    chk("rs_rd_data", 32'(bus.rd_data), 32'h0);
    chk("rs_rv", 32'(bus.rd_valid), 32'h0);
    tick();
    apply('{1'b1, 8'h9A, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0}, "rs_wr");
    apply('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1}, "rs_rd");

    // Back-to-back reads: one entry per cycle.
    for (int i = 0; i < 3; i++)
      apply('{1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0, 1'b1, i + 1, 1'b0, 1'b0}, "b2b_fill");
    bus.rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b2b_rv", 32'(bus.rd_valid), 32'h1);
      chk("b2b_count", 32'(bus.count), 32'(2 - i));
    end
    bus.rd_en = 1'b0;
    tick();
    chk("b2b_rv_end", 32'(bus.rd_valid), 32'h0);
    chk("b2b_empty", 32'(bus.empty), 32'h1);
    tick();

    chk("sb_leftover", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer directly downstream of the UART receiver. Captures each completed character (8-bit data plus parity-error status) on the receiver's one-cycle completion pulse. Stores it in a synchronous FIFO and presents it to the host-side read port with a registered read handshake. Also generates the RTS flow-control level and a sticky overrun flag for the register block.

## Interface
- DEPTH, 16, number of entries; power of two, 4..256
- ADDR_W, 4, log2(DEPTH); must match DEPTH
- AFULL_THRESH, 12, occupancy at or above which rts_n_out deasserts (1..DEPTH)
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous and active-low; single clock domain
- rx_done  in  1  one-cycle completion pulse from the receiver
- rx_data  in  8  received character; valid in the cycle after rx_done (unused upper bits already zero for 5-7 bit frames)
- parity_error  in  1  parity status of that character; valid in the cycle after rx_done
- rd_en  in  1  host read request, one entry per asserted cycle
- rd_data  out  8  read data, registered
- rd_perr  out  1  parity-error tag of rd_data, registered
- rd_valid  out  1  one-cycle pulse: rd_data/rd_perr updated this cycle
- empty  out  1  occupancy == 0
- full  out  1  occupancy == DEPTH
- count  out  ADDR_W+1  current occupancy, 0..DEPTH
- overrun  out  1  sticky: a character was dropped because FIFO was full
- clr_overrun  in  1  clears overrun
- rts_n_out  out  1  flow control to remote: 0 = ready, 1 = stop

## Operation
- Write path: rx_done registered into wr_pend; in the wr_pend cycle, {parity_error, rx_data} written at wr_ptr when not full (or when full with a simultaneous accepted read).
- Read path: rd_en with !empty → rd_data/rd_perr loaded from rd_ptr at the clock edge, rd_valid = 1 next cycle, rd_ptr advances; rd_en while empty ignored, rd_valid stays 0, no pointer change.
- Pointers ADDR_W bits, wrap modulo DEPTH; count tracks occupancy directly (+1 write, -1 read, unchanged on both).
- Simultaneous write and read:
  - Not empty, not full: both occur.
  - Full: both occur, no overrun, count stays DEPTH.
  - Empty: write only, read ignored, count becomes 1.
- Write while full with no accepted read: character dropped, pointers/count unchanged, overrun set.
- overrun: set wins over clr_overrun in the same cycle; otherwise clr_overrun clears it.
- rts_n_out registered: next value = (count_next >= AFULL_THRESH).
- rd_data/rd_perr hold their last value until the next successful read.

## Timing
- Reset (rst_n low at a clk edge):
  - Outputs: rd_data=0, rd_perr=0, rd_valid=0, empty=1, full=0, count=0, overrun=0, rts_n_out=0.
  - Internal: pointers and wr_pend cleared; reset mid-character or mid-read discards everything.
- rx_done at cycle N → write at edge ending N+1 → empty/count/full updated in N+2.
- rd_en at cycle N (not empty) → rd_valid and rd_data in N+1; back-to-back rd_en every cycle sustains one entry per cycle.
- rts_n_out reflects occupancy one cycle after count changes (same cycle as count update).
- Storage memory has no reset requirement; only pointers/flags reset.

## Configuration
- UART_RX_FIFO_PERR_TAG_EN
  - Defined: entries are 9 bits; rd_perr returns the stored parity-error tag.
  - Undefined: entries are 8 bits; parity_error ignored; rd_perr tied 0; all other behaviour identical.

## Test plan
- Reset then single write: rx_done pulse, rx_data=8'hA5, parity_error=0 → count=1, empty=0 two cycles later; rd_en → rd_valid pulse with rd_data=8'hA5, rd_perr=0, empty=1.
- Parity tag (macro defined): write 8'h3C with parity_error=1 → read returns rd_perr=1; macro undefined → rd_perr=0.
- Fill and overrun: write 16 characters 0x00..0x0F → full=1, rts_n_out=1 from the 12th write; 17th write 0xFF → dropped, overrun=1; reads return 0x00..0x0F in order; clr_overrun → overrun=0.
- Full with simultaneous read: FIFO full, write 0x55 in the same cycle as rd_en → overrun stays 0, count stays 16, 0x55 read last.
- Empty read/write collision: empty, rd_en in the wr_pend cycle → no rd_valid; count=1; next rd_en returns the written byte.
- Reset mid-stream: 5 entries stored, rst_n low one cycle → count=0, empty=1, overrun=0, rts_n_out=0, rd_data=0; subsequent write/read works from pointer 0.
